// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and branch-flush squash.
// Latency: one CLK edge from ID_* to EX_*.
// Backpressure: 'stall' holds PC and IF/ID for LOAD_STALL_CYCLES cycles per load-use hazard; EX gets bubbles meanwhile.
//
// Parameters:
//   LOAD_STALL_CYCLES  bubble cycles inserted per load-use hazard (1..15)
//   CTRL_W             packed control width {RegWre, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp[2:0]}
// Ports:
//   CLK, RST           rising-edge clock, asynchronous active-high reset
//   ID_*               decode-stage instruction: valid, rs/rt/dest indices, operands, immediate, control
//   EX_flush           taken branch/jump in EX; squashes the decode slot
//   WB_*               write-back port, used only for the optional operand bypass
//   stall              combinational hold request for PC and IF/ID
//   EX_*               registered instruction presented to EX (all zero for a bubble)
// Optional feature macro: WB_BYPASS_EN -- forward the write-back value into the captured operands.
module id_ex_stage #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CTRL_W            = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ID_valid,
    input  logic [4:0]        ID_rs,
    input  logic [4:0]        ID_rt,
    input  logic              ID_uses_rt,
    input  logic [4:0]        ID_addr,
    input  logic [31:0]       ID_readData1,
    input  logic [31:0]       ID_readData2,
    input  logic [31:0]       ID_imm,
    input  logic [CTRL_W-1:0] ID_ctrl,
    input  logic              EX_flush,
    input  logic              WB_RegWre,
    input  logic [4:0]        WB_addr,
    input  logic [31:0]       WB_writeData,
    output logic              stall,
    output logic              EX_valid,
    output logic [4:0]        EX_rs,
    output logic [4:0]        EX_rt,
    output logic [4:0]        EX_addr,
    output logic [31:0]       EX_readData1,
    output logic [31:0]       EX_readData2,
    output logic [31:0]       EX_imm,
    output logic [CTRL_W-1:0] EX_ctrl
);

    localparam int MEMREAD_BIT = 6;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        haz;
    logic        bubble;
    logic        stall_int;
    logic [31:0] op1, op2;

    // Load in EX whose destination is read by the instruction in decode.
    assign haz = EX_valid & EX_ctrl[MEMREAD_BIT] & (EX_addr != 5'd0) &
                 ((ID_rs == EX_addr) | (ID_uses_rt & (ID_rt == EX_addr))) & ID_valid;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_int = 1'b0;
        bubble    = 1'b0;
        if (EX_flush) begin
            // Flush wins over everything: squash decode, abandon any stall.
            state_nxt = RUN;
            cnt_nxt   = 4'd0;
            bubble    = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (haz) begin
                        stall_int = 1'b1;
                        bubble    = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = 4'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                STALL: begin
                    stall_int = 1'b1;
                    bubble    = 1'b1;
                    if (cnt <= 4'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
        if (!ID_valid) begin
            bubble = 1'b1;
        end
    end

    // Gate with RST so stall is low while reset is asserted, independent of state.
    assign stall = stall_int & ~RST;

    always_comb begin
        op1 = ID_readData1;
        op2 = ID_readData2;
`ifdef WB_BYPASS_EN
        if (WB_RegWre && (WB_addr != 5'd0) && (WB_addr == ID_rs)) begin
            op1 = WB_writeData;
        end
        if (WB_RegWre && (WB_addr != 5'd0) && (WB_addr == ID_rt)) begin
            op2 = WB_writeData;
        end
`endif
    end

`ifndef WB_BYPASS_EN
    // Register file writes mid-cycle, so the write-back port is not needed here.
    logic unused_wb;
    assign unused_wb = ^{WB_RegWre, WB_addr, WB_writeData};
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= RUN;
            cnt          <= 4'd0;
            EX_valid     <= 1'b0;
            EX_rs        <= 5'd0;
            EX_rt        <= 5'd0;
            EX_addr      <= 5'd0;
            EX_readData1 <= 32'd0;
            EX_readData2 <= 32'd0;
            EX_imm       <= 32'd0;
            EX_ctrl      <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (bubble) begin
                // Bubbles are fully zeroed so nothing downstream sees stale indices.
                EX_valid     <= 1'b0;
                EX_rs        <= 5'd0;
                EX_rt        <= 5'd0;
                EX_addr      <= 5'd0;
                EX_readData1 <= 32'd0;
                EX_readData2 <= 32'd0;
                EX_imm       <= 32'd0;
                EX_ctrl      <= '0;
            end else begin
                EX_valid     <= 1'b1;
                EX_rs        <= ID_rs;
                EX_rt        <= ID_rt;
                EX_addr      <= ID_addr;
                EX_readData1 <= op1;
                EX_readData2 <= op2;
                EX_imm       <= ID_imm;
                EX_ctrl      <= ID_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ID_valid = 1'b0;
    logic [4:0]  ID_rs = 5'd0, ID_rt = 5'd0, ID_addr = 5'd0;
    logic        ID_uses_rt = 1'b0;
    logic [31:0] ID_readData1 = 32'd0, ID_readData2 = 32'd0, ID_imm = 32'd0;
    logic [7:0]  ID_ctrl = 8'd0;
    logic        EX_flush = 1'b0;
    logic        WB_RegWre = 1'b0;
    logic [4:0]  WB_addr = 5'd0;
    logic [31:0] WB_writeData = 32'd0;

    // a: LOAD_STALL_CYCLES=1, b: LOAD_STALL_CYCLES=3
    logic        stall_a, ex_valid_a, stall_b, ex_valid_b;
    logic [4:0]  ex_rs_a, ex_rt_a, ex_addr_a, ex_rs_b, ex_rt_b, ex_addr_b;
    logic [31:0] ex_rd1_a, ex_rd2_a, ex_imm_a, ex_rd1_b, ex_rd2_b, ex_imm_b;
    logic [7:0]  ex_ctrl_a, ex_ctrl_b;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    id_ex_stage #(.LOAD_STALL_CYCLES(1), .CTRL_W(8)) dut_a (
        .CLK(CLK), .RST(RST), .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_uses_rt(ID_uses_rt), .ID_addr(ID_addr), .ID_readData1(ID_readData1),
        .ID_readData2(ID_readData2), .ID_imm(ID_imm), .ID_ctrl(ID_ctrl),
        .EX_flush(EX_flush), .WB_RegWre(WB_RegWre), .WB_addr(WB_addr),
        .WB_writeData(WB_writeData), .stall(stall_a), .EX_valid(ex_valid_a),
        .EX_rs(ex_rs_a), .EX_rt(ex_rt_a), .EX_addr(ex_addr_a),
        .EX_readData1(ex_rd1_a), .EX_readData2(ex_rd2_a), .EX_imm(ex_imm_a),
        .EX_ctrl(ex_ctrl_a)
    );

    id_ex_stage #(.LOAD_STALL_CYCLES(3), .CTRL_W(8)) dut_b (
        .CLK(CLK), .RST(RST), .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_uses_rt(ID_uses_rt), .ID_addr(ID_addr), .ID_readData1(ID_readData1),
        .ID_readData2(ID_readData2), .ID_imm(ID_imm), .ID_ctrl(ID_ctrl),
        .EX_flush(EX_flush), .WB_RegWre(WB_RegWre), .WB_addr(WB_addr),
        .WB_writeData(WB_writeData), .stall(stall_b), .EX_valid(ex_valid_b),
        .EX_rs(ex_rs_b), .EX_rt(ex_rt_b), .EX_addr(ex_addr_b),
        .EX_readData1(ex_rd1_b), .EX_readData2(ex_rd2_b), .EX_imm(ex_imm_b),
        .EX_ctrl(ex_ctrl_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urt, input logic [4:0] rd, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic [7:0] ctrl);
        ID_valid     = v;
        ID_rs        = rs;
        ID_rt        = rt;
        ID_uses_rt   = urt;
        ID_addr      = rd;
        ID_readData1 = d1;
        ID_readData2 = d2;
        ID_imm       = imm;
        ID_ctrl      = ctrl;
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid", {31'd0, ex_valid_a}, 32'd0);
        chk("rst_ctrl", {24'd0, ex_ctrl_a}, 32'd0);
        chk("rst_stall", {31'd0, stall_a}, 32'd0);
        tick();
        tick();
        RST = 1'b0;

        // Pass-through
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 5'd8, 32'h12345678, 32'h0BADF00D, 32'hFFFF_FFF0, 8'h81);
        chk("pt_stall", {31'd0, stall_a}, 32'd0);
        tick();
        chk("pt_valid", {31'd0, ex_valid_a}, 32'd1);
        chk("pt_rs", {27'd0, ex_rs_a}, 32'd3);
        chk("pt_rt", {27'd0, ex_rt_a}, 32'd4);
        chk("pt_addr", {27'd0, ex_addr_a}, 32'd8);
        chk("pt_rd1", ex_rd1_a, 32'h12345678);
        chk("pt_rd2", ex_rd2_a, 32'h0BADF00D);
        chk("pt_imm", ex_imm_a, 32'hFFFF_FFF0);
        chk("pt_ctrl", {24'd0, ex_ctrl_a}, 32'h81);

        // Load-use with one bubble (dut_a)
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 32'h0, 32'h0, 32'h10, 8'hC0);
        tick();
        set_id(1'b1, 5'd5, 5'd2, 1'b0, 5'd6, 32'h0000AAAA, 32'h0, 32'h0, 8'h80);
        chk("lu1_stall", {31'd0, stall_a}, 32'd1);
        tick();
        chk("lu1_bub_valid", {31'd0, ex_valid_a}, 32'd0);
        chk("lu1_bub_ctrl", {24'd0, ex_ctrl_a}, 32'd0);
        chk("lu1_bub_rd1", ex_rd1_a, 32'd0);
        chk("lu1_stall_end", {31'd0, stall_a}, 32'd0);
        tick();
        chk("lu1_cap_valid", {31'd0, ex_valid_a}, 32'd1);
        chk("lu1_cap_rs", {27'd0, ex_rs_a}, 32'd5);
        chk("lu1_cap_rd1", ex_rd1_a, 32'h0000AAAA);
        // dut_b is still mid-stall here
        chk("b_midstall", {31'd0, stall_b}, 32'd1);

        // Asynchronous reset mid-stream / mid-stall
        RST = 1'b1;
        #1;
        chk("arst_valid", {31'd0, ex_valid_a}, 32'd0);
        chk("arst_rd1", ex_rd1_a, 32'd0);
        chk("arst_rs", {27'd0, ex_rs_a}, 32'd0);
        chk("arst_stall_b", {31'd0, stall_b}, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd9, 32'h12345678, 32'h0, 32'h0, 8'h81);
        chk("post_rst_stall_b", {31'd0, stall_b}, 32'd0);
        tick();
        chk("post_rst_valid_b", {31'd0, ex_valid_b}, 32'd1);
        chk("post_rst_rd1_b", ex_rd1_b, 32'h12345678);

        // Three-cycle stall on rt (dut_b)
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 32'h0, 32'h0, 32'h0, 8'hC0);
        tick();
        set_id(1'b1, 5'd2, 5'd5, 1'b1, 5'd9, 32'h0, 32'h00005555, 32'h0, 8'h80);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ms_stall%0d", i), {31'd0, stall_b}, 32'd1);
            tick();
            chk($sformatf("ms_bubble%0d", i), {31'd0, ex_valid_b}, 32'd0);
        end
        chk("ms_stall_end", {31'd0, stall_b}, 32'd0);
        tick();
        chk("ms_cap_valid", {31'd0, ex_valid_b}, 32'd1);
        chk("ms_cap_rt", {27'd0, ex_rt_b}, 32'd5);
        chk("ms_cap_rd2", ex_rd2_b, 32'h00005555);

        // Same dependency but rt not read: no stall
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 32'h0, 32'h0, 32'h0, 8'hC0);
        tick();
        set_id(1'b1, 5'd2, 5'd5, 1'b0, 5'd9, 32'h0, 32'h0, 32'h0, 8'h80);
        chk("nort_stall", {31'd0, stall_b}, 32'd0);
        tick();
        chk("nort_valid", {31'd0, ex_valid_b}, 32'd1);

        // Load to r0 never stalls
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 8'hC0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 32'h0, 32'h0, 32'h0, 8'h80);
        chk("r0_stall_b", {31'd0, stall_b}, 32'd0);
        chk("r0_stall_a", {31'd0, stall_a}, 32'd0);
        tick();

        // Flush in the second stall cycle (dut_b)
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 32'h0, 32'h0, 32'h0, 8'hC0);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 1'b0, 5'd9, 32'h00000077, 32'h0, 32'h0, 8'h80);
        chk("fl_stall1", {31'd0, stall_b}, 32'd1);
        tick();
        EX_flush = 1'b1;
        #1;
        chk("fl_stall2", {31'd0, stall_b}, 32'd0);
        tick();
        EX_flush = 1'b0;
        #1;
        chk("fl_bub_valid", {31'd0, ex_valid_b}, 32'd0);
        chk("fl_bub_ctrl", {24'd0, ex_ctrl_b}, 32'd0);
        chk("fl_run_stall", {31'd0, stall_b}, 32'd0);
        tick();
        chk("fl_cap_valid", {31'd0, ex_valid_b}, 32'd1);
        chk("fl_cap_rd1", ex_rd1_b, 32'h00000077);

        // Invalid decode slot is captured as a bubble
        set_id(1'b0, 5'd4, 5'd4, 1'b1, 5'd4, 32'h11111111, 32'h22222222, 32'h3, 8'h9F);
        tick();
        chk("inv_valid", {31'd0, ex_valid_a}, 32'd0);
        chk("inv_rd1", ex_rd1_a, 32'd0);
        chk("inv_ctrl", {24'd0, ex_ctrl_a}, 32'd0);

        // Write-back bypass
        WB_RegWre    = 1'b1;
        WB_addr      = 5'd7;
        WB_writeData = 32'hDEADBEEF;
        set_id(1'b1, 5'd7, 5'd7, 1'b1, 5'd10, 32'h0, 32'h0, 32'h0, 8'h80);
        tick();
`ifdef WB_BYPASS_EN
        chk("byp_rd1", ex_rd1_a, 32'hDEADBEEF);
        chk("byp_rd2", ex_rd2_a, 32'hDEADBEEF);
`else
        chk("byp_rd1", ex_rd1_a, 32'h0);
        chk("byp_rd2", ex_rd2_a, 32'h0);
`endif
        // Write-back to r0 is never forwarded
        WB_addr = 5'd0;
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd10, 32'h00000042, 32'h0, 32'h0, 8'h80);
        tick();
        chk("byp_r0", ex_rd1_a, 32'h00000042);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that sits directly downstream of the register file. It captures the operands read in decode, the selected destination address and the control bits, and presents them to EX one cycle later.
- It owns load-use hazard detection. A small FSM stalls IF/ID and inserts EX bubbles for a configurable number of cycles.
- It honours branch flush from EX.

Parameters:
- LOAD_STALL_CYCLES, 1, number of bubble cycles inserted per load-use hazard (1..15).
- CTRL_W, 8, width of the packed control bundle {RegWre, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp[2:0]}.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ID_valid  in  1  decode slot holds a real instruction.
- ID_rs  in  5  source register 1 index.
- ID_rt  in  5  source register 2 index.
- ID_uses_rt  in  1  instruction actually reads rt.
- ID_addr  in  5  destination register selected in decode.
- ID_readData1  in  32  register-file operand 1.
- ID_readData2  in  32  register-file operand 2.
- ID_imm  in  32  sign/zero-extended immediate.
- ID_ctrl  in  CTRL_W  control bundle; bit6 = MemRead, bit7 = RegWre.
- EX_flush  in  1  branch/jump taken in EX; squash decode.
- WB_RegWre  in  1  write-back enable.
- WB_addr  in  5  write-back address.
- WB_writeData  in  32  write-back data.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- EX_valid  out  1  EX slot valid.
- EX_rs, EX_rt, EX_addr  out  5 each  registered indices.
- EX_readData1, EX_readData2, EX_imm  out  32 each  registered operands.
- EX_ctrl  out  CTRL_W  registered control; all zero for a bubble.

Behaviour:
- Reset (RST=1, asynchronous): all EX_* outputs = 0, FSM = RUN, stall counter = 0. While RST is held, stall = 0.
- Latency: one rising edge from ID_* to EX_*.
- Hazard term: haz = EX_valid & EX_ctrl[6] & (EX_addr != 0) & ((ID_rs == EX_addr) | (ID_uses_rt & ID_rt == EX_addr)) & ID_valid.
- FSM RUN:
  - Normal case: capture ID_* into EX_*; EX_valid = ID_valid.
  - If haz & !EX_flush: stall = 1 this cycle; EX receives a bubble (EX_valid = 0, EX_ctrl = 0, data fields also zeroed).
    - LOAD_STALL_CYCLES = 1: stay in RUN.
    - LOAD_STALL_CYCLES > 1: go to STALL with cnt = LOAD_STALL_CYCLES-1.
- FSM STALL:
  - stall = 1; bubble into EX each cycle; cnt decrements.
  - When cnt reaches 1, the next edge returns to RUN, with stall = 0 on that RUN cycle unless haz recurs.
  - Total stall cycles per hazard = LOAD_STALL_CYCLES.
- EX_flush (highest priority, any state): next edge writes a bubble into EX, FSM -> RUN, cnt -> 0. stall = 0 in a flush cycle.
- ID_valid = 0: a bubble is captured; no hazard is raised.
- EX_addr = 0 never raises a hazard.
- Reset mid-stall: immediate return to RUN; outputs cleared.
- No width conversion: all data is passed through bit-exact.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: on capture, if WB_RegWre & WB_addr != 0 & WB_addr == ID_rs, EX_readData1 takes WB_writeData instead of ID_readData1. The same rule applies to rt / EX_readData2. Bypass is not applied on bubble captures.
- Not defined: WB_* ports are present but ignored. Operands are taken from ID_readData1/2 only, relying on the register file's mid-cycle write.

Test Plan:
- Reset: RST pulsed for 2 cycles mid-stream -> all EX_* = 0 and stall = 0 asynchronously; the first post-reset edge captures ID_* normally.
- Pass-through: ID_rs=3, ID_readData1=0x12345678, ID_ctrl=0x81, ID_valid=1 -> after one edge EX_rs=3, EX_readData1=0x12345678, EX_ctrl=0x81, EX_valid=1.
- Load-use, LOAD_STALL_CYCLES=1: EX holds lw with EX_addr=5, EX_ctrl[6]=1; ID_rs=5 -> stall=1 for exactly 1 cycle, then EX_valid=0 and EX_ctrl=0; the next cycle captures the dependent instruction.
- Multi-cycle stall, LOAD_STALL_CYCLES=3, ID_rt=5 with ID_uses_rt=1 -> stall high for exactly 3 cycles and 3 bubbles, then capture. Repeating with ID_uses_rt=0 -> no stall.
- Flush during STALL: assert EX_flush in the 2nd stall cycle -> stall=0 that cycle, next EX is a bubble, FSM in RUN. Also check EX_addr=0 with MemRead -> no stall.
- WB_BYPASS_EN: WB_RegWre=1, WB_addr=7, WB_writeData=0xDEADBEEF, ID_rs=7, ID_readData1=0x0 -> EX_readData1=0xDEADBEEF. The same stimulus without the macro -> EX_readData1=0x0.
